fp_adder_arbiter: RTL and testbench
===================================

# fp_adder_arbiter

Shares one combinational `fp_adder` (single-precision, ports `a`, `b`, `s`) among NREQ requesters. Each requester issues add or subtract operations through a valid/ready handshake. A round-robin arbiter admits at most one operation per cycle into a 2-stage pipeline. Results return on a single tagged response port with backpressure. The block sits between the FP-consuming engines and the one physical adder instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `ID_W`, `$clog2(NREQ)`: width of the requester tag.
- `CNT_W`, 16: width of the completed-operation counter.

One clock; reset is asynchronous and active-high.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in [NREQ]: requester i presents an operation.
- `req_ready` out [NREQ]: requester i's operation is accepted this cycle.
- `req_a` in [NREQ][32]: operand a, IEEE-754 single.
- `req_b` in [NREQ][32]: operand b.
- `req_sub` in [NREQ]: 1 = a − b, 0 = a + b.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_s` out 32: result.
- `rsp_id` out ID_W: index of the originating requester.
- `op_count` out CNT_W: number of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- **Subtraction** is implemented as `b ^ 32'h80000000` into the adder. No other operand modification.
- **Arbitration** is round-robin over requesters with `req_valid` = 1, searching upward from pointer `ptr`.
  - `req_ready[i]` = 1 only for the winner, and only when stage 1 can accept.
  - At most one bit of `req_ready` is set.
  - `req_ready` may depend combinationally on `req_valid`.
  - Requesters must hold a, b, sub and valid stable until the handshake completes.
- **Pointer update:** on a handshake with requester i, `ptr <= (i+1) mod NREQ`. With no handshake, `ptr` holds.
- **Stage 1** registers `{s1_v, s1_a, s1_b', s1_id}`, where `s1_b'` is b after the sign flip.
- **Stage 2:** the adder is driven from stage 1, and `{s2_v, s2_s, s2_id}` registers its output.
  - `rsp_valid` = `s2_v`, `rsp_s` = `s2_s`, `rsp_id` = `s2_id`.
- **Flow control:**
  - `adv2 = !s2_v || rsp_ready`.
  - `adv1 = !s1_v || adv2`.
  - Stage 2 loads from stage 1 when `adv2`. It clears when `adv2 && !s1_v`.
  - Stage 1 loads a grant when `adv1`. It clears when `adv1` and there is no grant.
- **Counter:** `op_count` increments on each `rsp_valid && rsp_ready`.
- **Ordering:** responses leave in acceptance order. The pipeline never drops or duplicates an operation.
- **Reset values:** `s1_v`, `s2_v`, `rsp_s`, `rsp_id`, `ptr` and `op_count` are all 0. Therefore `rsp_valid` = 0 and all `req_ready` = 0 while `rst` is high.

## Timing
- **Latency:** an operation accepted at edge N is presented on `rsp_valid` after edge N+1, with no backpressure.
- **Throughput:** 1 operation per cycle while `rsp_ready` = 1.
- **Capacity:** 2 operations in flight.
  - With `rsp_ready` held at 0, the pipeline fills, then `req_ready` stays 0.
  - Results stay stable while `rsp_valid && !rsp_ready`.
- **Simultaneous events:**
  - A full pipeline with `rsp_ready` = 1 accepts a new request in the same cycle as the response handshake (pass-through).
  - If only one requester is valid, it may win on consecutive cycles.
- **Reset mid-operation:** in-flight operations are discarded and outputs drop to reset values immediately (asynchronously). After deassertion, arbitration restarts from requester 0.
- **Pointer range:** `ptr` stays within 0..NREQ−1. It wraps from NREQ−1 to 0.

## Structure
- Package `fp_arb_pkg`:
  - `FP_W = 32`, `SIGN_BIT = 31`.
  - `typedef logic [31:0] fp_t`.
  - A struct `fp_op_t` holding `{a, b, id}`, used for the stage-1 register.
- One sub-module instance: the existing `fp_adder`, between stage 1 and stage 2.
- The round-robin grant logic stays inline. Do not add a separate arbiter module.

## Test plan
- **Single add:** requester 2 sends a = `3f800000`, b = `40000000`, sub = 0. Required: `rsp_s` = `40400000`, `rsp_id` = 2, two cycles after the handshake, and `op_count` = 1.
- **Single subtract:** requester 0 sends a = `40400000`, b = `3f800000`, sub = 1. Required: `rsp_s` = `40000000`, `rsp_id` = 0.
- **Round-robin:** all 4 requesters hold valid continuously, with `rsp_ready` = 1. Required:
  - grant order 0, 1, 2, 3, 0;
  - `rsp_id` sequence 0, 1, 2, 3, 0 on consecutive cycles;
  - exactly one `req_ready` set per cycle.
- **Backpressure:** 3 requesters are valid and `rsp_ready` is held low for 4 cycles. Required:
  - exactly 2 acceptances occur, then `req_ready` stays all-0;
  - `rsp_s` and `rsp_id` stay stable;
  - after `rsp_ready` rises, the results drain in order and the third request is accepted in the same cycle as the first drain.
- **Reset mid-flight:** assert `rst` with 2 operations in flight. Required:
  - `rsp_valid` = 0 immediately, without waiting for a clock edge;
  - `op_count` = 0;
  - after release, a new request from requester 3 completes normally with `rsp_id` = 3.
- **Counter wrap:** with `CNT_W` = 4, complete 17 operations. Required: `op_count` = 1.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared types for the FP adder arbiter: operand format, stage-1 record and
// the sign-flip helper used to turn a subtract into an add.
package fp_arb_pkg;

   localparam int FP_W     = 32;
   localparam int SIGN_BIT = 31;
   localparam int ID_MAX_W = 3;   // NREQ is at most 8

   typedef logic [FP_W-1:0] fp_t;

   localparam fp_t FP_QNAN = 32'h7fc0_0000;

   typedef struct packed {
      fp_t                 a;
      fp_t                 b;
      logic [ID_MAX_W-1:0] id;
   } fp_op_t;

   function automatic fp_t fp_negate(input fp_t x);
      return x ^ (fp_t'(1) << SIGN_BIT);
   endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with subnormal inputs/outputs, infinities and a canonical quiet NaN.
module fp_adder
   import fp_arb_pkg::*;
(
   input  fp_t a,
   input  fp_t b,
   output fp_t s
);

   logic        a_nan, b_nan, a_inf, b_inf;
   logic        swap, big_sign, eff_sub, sticky, rnd_up;
   logic [30:0] big_mag, sml_mag;
   logic [7:0]  big_e, sml_e, diff;
   logic [23:0] big_m, sml_m;
   logic [26:0] sml_ext, sml_al, norm;
   logic [27:0] sum;
   logic [4:0]  msb;
   logic [9:0]  lz, lim, shamt, exp_n;
   logic [24:0] mant_r;

   always_comb begin
      a_nan = (&a[30:23]) & (|a[22:0]);
      b_nan = (&b[30:23]) & (|b[22:0]);
      a_inf = (&a[30:23]) & ~(|a[22:0]);
      b_inf = (&b[30:23]) & ~(|b[22:0]);

      // Order operands by magnitude so the alignment shift is always rightward.
      swap     = b[30:0] > a[30:0];
      big_mag  = swap ? b[30:0] : a[30:0];
      sml_mag  = swap ? a[30:0] : b[30:0];
      big_sign = swap ? b[31] : a[31];
      eff_sub  = a[31] ^ b[31];

      big_e = (big_mag[30:23] == 8'd0) ? 8'd1 : big_mag[30:23];
      sml_e = (sml_mag[30:23] == 8'd0) ? 8'd1 : sml_mag[30:23];
      big_m = {big_mag[30:23] != 8'd0, big_mag[22:0]};
      sml_m = {sml_mag[30:23] != 8'd0, sml_mag[22:0]};
      diff  = big_e - sml_e;

      // Three extra bits below the LSB: guard, round, sticky.
      sml_ext = {sml_m, 3'b000};
      sticky  = 1'b0;
      if (diff >= 8'd27) begin
         sml_al = {26'd0, |sml_m};
      end else begin
         sml_al    = sml_ext >> diff;
         sticky    = |(sml_ext & ~({27{1'b1}} << diff));
         sml_al[0] = sml_al[0] | sticky;
      end

      sum = eff_sub ? ({1'b0, big_m, 3'b000} - {1'b0, sml_al})
                    : ({1'b0, big_m, 3'b000} + {1'b0, sml_al});

      msb = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) msb = 5'(i);
      end
      lz    = 10'd26 - {5'd0, msb};
      lim   = {2'b00, big_e} - 10'd1;
      // Left shift is capped so the exponent never drops below the subnormal floor.
      shamt = (lz < lim) ? lz : lim;

      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         exp_n = {2'b00, big_e} + 10'd1;
      end else begin
         norm  = sum[26:0] << shamt;
         exp_n = {2'b00, big_e} - shamt;
      end

      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
      if (mant_r[24]) begin
         mant_r = mant_r >> 1;
         exp_n  = exp_n + 10'd1;
      end

      if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) begin
         s = FP_QNAN;
      end else if (a_inf) begin
         s = a;
      end else if (b_inf) begin
         s = b;
      end else if (sum == 28'd0) begin
         s = {a[31] & b[31], 31'd0};
      end else if (exp_n >= 10'd255) begin
         s = {big_sign, 8'hff, 23'd0};
      end else begin
         s = {big_sign, mant_r[23] ? exp_n[7:0] : 8'd0, mant_r[22:0]};
      end
   end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin front end sharing one fp_adder among NREQ requesters through a
// two-stage pipeline with a single tagged, backpressured response port.
module fp_adder_arbiter
   import fp_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int ID_W  = $clog2(NREQ),
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  fp_t  [NREQ-1:0]       req_a,
   input  fp_t  [NREQ-1:0]       req_b,
   input  logic [NREQ-1:0]       req_sub,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output fp_t                   rsp_s,
   output logic [ID_W-1:0]       rsp_id,
   output logic [CNT_W-1:0]      op_count
);

   logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   fp_op_t           s1_op_q, s1_op_d;
   fp_t              s2_s_q, s2_s_d, add_s;
   logic [ID_W-1:0]  s2_id_q, s2_id_d, ptr_q, ptr_d, grant_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             grant_found, adv1, adv2, accept, rsp_fire;
   logic             unused_id;

   function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] p, input int k);
      int t;
      t = int'(p) + k;
      if (t >= NREQ) t = t - NREQ;
      return ID_W'(t);
   endfunction

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_found && req_valid[rr_index(ptr_q, k)]) begin
            grant_found = 1'b1;
            grant_idx   = rr_index(ptr_q, k);
         end
      end
   end

   assign adv2     = !s2_v_q || rsp_ready;
   assign adv1     = !s1_v_q || adv2;
   // Grants are suppressed while reset is held, even though stage 1 looks empty.
   assign accept   = grant_found && adv1 && !rst;
   assign rsp_fire = s2_v_q && rsp_ready;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
   end

   always_comb begin
      s1_v_d  = s1_v_q;
      s1_op_d = s1_op_q;
      s2_v_d  = s2_v_q;
      s2_s_d  = s2_s_q;
      s2_id_d = s2_id_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      if (adv1) begin
         s1_v_d = grant_found;
         if (grant_found) begin
            s1_op_d.a  = req_a[grant_idx];
            s1_op_d.b  = req_sub[grant_idx] ? fp_negate(req_b[grant_idx]) : req_b[grant_idx];
            s1_op_d.id = ID_MAX_W'(grant_idx);
         end
      end

      if (adv2) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_s_d  = add_s;
            s2_id_d = s1_op_q.id[ID_W-1:0];
         end
      end

      if (accept) begin
         ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (rsp_fire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q  <= 1'b0;
         s1_op_q <= '0;
         s2_v_q  <= 1'b0;
         s2_s_q  <= '0;
         s2_id_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         s1_v_q  <= s1_v_d;
         s1_op_q <= s1_op_d;
         s2_v_q  <= s2_v_d;
         s2_s_q  <= s2_s_d;
         s2_id_q <= s2_id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   fp_adder u_fp_adder (
      .a (s1_op_q.a),
      .b (s1_op_q.b),
      .s (add_s)
   );

   // Upper tag bits are padding when NREQ is below the package maximum.
   assign unused_id = ^s1_op_q.id;

   assign rsp_valid = s2_v_q;
   assign rsp_s     = s2_s_q;
   assign rsp_id    = s2_id_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: single ops, adder corner vectors,
// reset mid-flight, round-robin order, backpressure and counter wrap.
module tb_fp_adder_arbiter;

   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] s;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NREQ-1:0]        req_valid, req_ready, req_sub;
   logic [NREQ-1:0][31:0]  req_a, req_b;
   logic                   rsp_valid, rsp_ready;
   logic [31:0]            rsp_s;
   logic [ID_W-1:0]        rsp_id;
   logic [CNT_W-1:0]       op_count;

   int               checks   = 0;
   int               failures = 0;
   logic [CNT_W-1:0] exp_cnt;
   logic [31:0]      fp_n [7];
   vec_t             vecs [7];
   logic [3:0]       bp_grant [4];

   always #5 clk = ~clk;

   fp_adder_arbiter #(
      .NREQ  (NREQ),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_s     (rsp_s),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp_v);
      end
   endtask

   // One isolated operation with rsp_ready high: ready, latency, result, count.
   task automatic do_op(input string tag, input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic sub, input logic [31:0] exp_s);
      @(negedge clk);
      req_a[id]   = a;
      req_b[id]   = b;
      req_sub[id] = sub;
      req_valid   = 4'(1 << id);
      #1 check_val({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
      @(posedge clk); #1;
      req_valid = '0;
      check_val({tag, ".lat"}, 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check_val({tag, ".valid"}, 32'(rsp_valid), 32'd1);
      check_val({tag, ".s"}, rsp_s, exp_s);
      check_val({tag, ".id"}, 32'(rsp_id), 32'(id));
      exp_cnt++;
      @(posedge clk); #1;
      check_val({tag, ".cnt"}, 32'(op_count), 32'(exp_cnt));
      $display("op %s req=%0d a=%h b=%h sub=%0d expect=%h", tag, id, a, b, sub, exp_s);
   endtask

   initial begin
      fp_n[0] = 32'h0000_0000; fp_n[1] = 32'h3f80_0000; fp_n[2] = 32'h4000_0000;
      fp_n[3] = 32'h4040_0000; fp_n[4] = 32'h4080_0000; fp_n[5] = 32'h40a0_0000;
      fp_n[6] = 32'h40c0_0000;
      vecs[0] = '{32'h3f80_0000, 32'h3380_0000, 1'b0, 32'h3f80_0000};
      vecs[1] = '{32'h3f80_0001, 32'h3380_0000, 1'b0, 32'h3f80_0002};
      vecs[2] = '{32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000};
      vecs[3] = '{32'h7f7f_ffff, 32'h7f7f_ffff, 1'b0, 32'h7f80_0000};
      vecs[4] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002};
      vecs[5] = '{32'h7f80_0000, 32'h7f80_0000, 1'b1, 32'h7fc0_0000};
      vecs[6] = '{32'h3fc0_0000, 32'h4020_0000, 1'b1, 32'hbf80_0000};
      bp_grant[0] = 4'b0001; bp_grant[1] = 4'b0010;
      bp_grant[2] = 4'b0000; bp_grant[3] = 4'b0000;

      req_valid = '1;
      req_sub   = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      exp_cnt   = '0;

      // Reset state, with every requester asking.
      repeat (2) @(negedge clk);
      check_val("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst.req_ready", 32'(req_ready), 32'd0);
      check_val("rst.op_count", 32'(op_count), 32'd0);
      check_val("rst.rsp_s", rsp_s, 32'd0);
      check_val("rst.rsp_id", 32'(rsp_id), 32'd0);
      rst       = 1'b0;
      req_valid = '0;

      do_op("add", 2, 32'h3f80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
      do_op("sub", 0, 32'h4040_0000, 32'h3f80_0000, 1'b1, 32'h4000_0000);
      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), 1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s);
      end

      // Reset with two operations in flight.
      @(negedge clk);
      rsp_ready = 1'b0;
      req_a[1] = fp_n[1]; req_b[1] = fp_n[1]; req_sub[1] = 1'b0;
      req_a[2] = fp_n[2]; req_b[2] = fp_n[1]; req_sub[2] = 1'b0;
      req_valid = 4'b0110;
      @(posedge clk); @(posedge clk); #1;
      req_valid = '1;
      @(negedge clk);
      check_val("rstmid.pre_valid", 32'(rsp_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_val("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rstmid.op_count", 32'(op_count), 32'd0);
      check_val("rstmid.req_ready", 32'(req_ready), 32'd0);
      check_val("rstmid.rsp_s", rsp_s, 32'd0);
      check_val("rstmid.rsp_id", 32'(rsp_id), 32'd0);
      exp_cnt = '0;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      do_op("rstmid.req3", 3, fp_n[2], fp_n[2], 1'b0, fp_n[4]);

      // Round-robin with all four requesters holding valid.
      for (int i = 0; i < NREQ; i++) begin
         req_a[i] = fp_n[i + 1];
         req_b[i] = fp_n[1];
      end
      req_sub = '0;
      @(negedge clk);
      req_valid = '1;
      for (int c = 0; c < 7; c++) begin
         #1;
         check_val($sformatf("rr.grant%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
         check_val($sformatf("rr.onehot%0d", c), 32'($countones(req_ready)), 32'd1);
         if (c >= 2) begin
            check_val($sformatf("rr.valid%0d", c), 32'(rsp_valid), 32'd1);
            check_val($sformatf("rr.id%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
            check_val($sformatf("rr.s%0d", c), rsp_s, fp_n[(c - 2) % 4 + 2]);
         end
         $display("rr cycle=%0d req_ready=%b rsp_valid=%0d rsp_id=%0d", c, req_ready, rsp_valid, rsp_id);
         @(negedge clk);
      end
      req_valid = '0;
      #1;
      check_val("rr.drain_id5", 32'(rsp_id), 32'd1);
      check_val("rr.drain_s5", rsp_s, fp_n[3]);
      @(negedge clk);
      check_val("rr.drain_id6", 32'(rsp_id), 32'd2);
      check_val("rr.drain_s6", rsp_s, fp_n[4]);
      @(negedge clk);
      check_val("rr.empty", 32'(rsp_valid), 32'd0);
      exp_cnt = exp_cnt + 4'd7;
      check_val("rr.cnt", 32'(op_count), 32'(exp_cnt));

      // Backpressure: three requesters, consumer stalled for four cycles.
      rsp_ready = 1'b0;
      req_valid = 4'b0111;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_val($sformatf("bp.grant%0d", c), 32'(req_ready), 32'(bp_grant[c]));
         if (c >= 2) begin
            check_val($sformatf("bp.valid%0d", c), 32'(rsp_valid), 32'd1);
            check_val($sformatf("bp.id%0d", c), 32'(rsp_id), 32'd0);
            check_val($sformatf("bp.s%0d", c), rsp_s, fp_n[2]);
         end
         $display("bp cycle=%0d req_ready=%b rsp_valid=%0d rsp_id=%0d", c, req_ready, rsp_valid, rsp_id);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check_val("bp.passthru_ready", 32'(req_ready), 32'b0100);
      check_val("bp.drain_id0", 32'(rsp_id), 32'd0);
      @(negedge clk);
      req_valid = '0;
      check_val("bp.drain_id1", 32'(rsp_id), 32'd1);
      check_val("bp.drain_s1", rsp_s, fp_n[3]);
      @(negedge clk);
      check_val("bp.drain_id2", 32'(rsp_id), 32'd2);
      check_val("bp.drain_s2", rsp_s, fp_n[4]);
      @(negedge clk);
      check_val("bp.empty", 32'(rsp_valid), 32'd0);
      exp_cnt = exp_cnt + 4'd3;
      check_val("bp.cnt", 32'(op_count), 32'(exp_cnt));

      // Counter wrap: 17 back-to-back operations from a single requester.
      @(negedge clk);
      rst = 1'b1;
      #2 rst = 1'b0;
      req_a[1]   = fp_n[1];
      req_b[1]   = fp_n[1];
      req_sub[1] = 1'b0;
      req_valid  = 4'b0010;
      for (int k = 0; k < 17; k++) begin
         #1 check_val($sformatf("wrap.ready%0d", k), 32'(req_ready), 32'b0010);
         @(negedge clk);
      end
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("wrap.rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("wrap.op_count", 32'(op_count), 32'd1);
      $display("wrap ops=17 op_count=%0d", op_count);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
